// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 2^AW x DW RAM; reads return one cycle after grant.
// Optional saturating grant/conflict counters when MEM_RR_ARB_PERF_CNT_EN is defined.
module mem_rr_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_we,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_wdata,
    input  logic [DW/8-1:0] req0_be,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_we,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_wdata,
    input  logic [DW/8-1:0] req1_be,
`ifdef MEM_RR_ARB_PERF_CNT_EN
    output logic [15:0]     gnt0_cnt,
    output logic [15:0]     gnt1_cnt,
    output logic [15:0]     conflict_cnt,
`endif
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_rdata
);
    localparam int BW = DW / 8;

    logic            last_gnt;
    logic            gnt0, gnt1, gnt_any, sel;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [BW-1:0]   sel_be;
    logic [DW-1:0]   mem [2**AW];

    // Grant only the port that was not served last when both ask; ready is gated low during reset.
    assign gnt0    = rst_n & req0_valid & (~req1_valid | last_gnt);
    assign gnt1    = rst_n & req1_valid & (~req0_valid | ~last_gnt);
    assign gnt_any = gnt0 | gnt1;
    assign sel     = gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign sel_we    = sel ? req1_we    : req0_we;
    assign sel_addr  = sel ? req1_addr  : req0_addr;
    assign sel_wdata = sel ? req1_wdata : req0_wdata;
    assign sel_be    = sel ? req1_be    : req0_be;

    always_ff @(posedge clk) begin
        if (gnt_any && sel_we) begin
            for (int b = 0; b < BW; b++) begin
                if (sel_be[b]) mem[sel_addr][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= gnt_any & ~sel_we;
            if (gnt_any) last_gnt <= sel;
            if (gnt_any && !sel_we) begin
                rsp_id    <= sel;
                rsp_rdata <= mem[sel_addr];
            end
        end
    end

`ifdef MEM_RR_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt     <= '0;
            gnt1_cnt     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt0 && gnt0_cnt != 16'hFFFF) gnt0_cnt <= gnt0_cnt + 16'd1;
            if (gnt1 && gnt1_cnt != 16'hFFFF) gnt1_cnt <= gnt1_cnt + 16'd1;
            if (req0_valid && req1_valid && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule
